commu_sched: RTL and testbench

- Frame scheduler sitting in front of commu_push inside commu_top.
- Arbitrates round-robin between two frame sources (ch0, ch1) that each have a complete frame buffered and waiting.
- Drives the buffer-select mux, fires commu_push, waits for its completion, then enforces a minimum inter-frame gap before serving the next request.
- Keeps a frame counter and an optional push-timeout watchdog.

---
 rtl/commu_pkg.sv | 13 +
 rtl/commu_rr_arb2.sv | 38 +++
 rtl/commu_sched.sv | 171 +++++++++++++++++
 tb/tb_commu_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commu_pkg.sv
// Shared state and channel encodings for the commu frame scheduler.
package commu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage

// File: rtl/commu_rr_arb2.sv
// Two-input round-robin arbiter; last_gnt flips priority only when a grant is taken.
module commu_rr_arb2
   import commu_pkg::*;
(
   input  logic clk_sys,
   input  logic rst_n,
   input  logic req_ch0,
   input  logic req_ch1,
   input  logic take,
   output logic gnt_vld,
   output logic gnt
);

   logic last_gnt_d;
   logic last_gnt_q;

   always_comb begin
      gnt_vld = req_ch0 | req_ch1;
      if (req_ch0 && req_ch1) begin
         gnt = ~last_gnt_q;
      end else if (req_ch1) begin
         gnt = CH1;
      end else begin
         gnt = CH0;
      end
      last_gnt_d = take ? gnt : last_gnt_q;
   end

   // Reset to CH1 so that ch0 wins the very first tie.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= CH1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule

// File: rtl/commu_sched.sv
// Frame scheduler in front of commu_push: round-robin grant, push handshake, inter-frame gap.
// Optional push-timeout watchdog enabled by defining COMMU_SCHED_TMO_EN.
module commu_sched
   import commu_pkg::*;
#(
   parameter int GAP_CYC = 16,
   parameter int TMO_CYC = 65535
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        cfg_en,
   input  logic        req_ch0,
   input  logic        req_ch1,
   output logic        ack_ch0,
   output logic        ack_ch1,
   output logic        buf_sel,
   output logic        fire_push,
   input  logic        done_push,
   output logic        busy,
   output logic [15:0] frm_cnt,
   output logic        err_tmo,
   input  logic        clr_err
);

   state_t      state_q, state_d;
   logic        buf_sel_q, buf_sel_d;
   logic        fire_push_q, fire_push_d;
   logic        ack_ch0_q, ack_ch0_d;
   logic        ack_ch1_q, ack_ch1_d;
   logic        busy_q, busy_d;
   logic [15:0] frm_cnt_q, frm_cnt_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;

   logic gnt_vld;
   logic gnt;
   logic take;
   logic done_ok;
   logic tmo_hit;

   commu_rr_arb2 u_arb (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .req_ch0 (req_ch0),
      .req_ch1 (req_ch1),
      .take    (take),
      .gnt_vld (gnt_vld),
      .gnt     (gnt)
   );

   assign take    = (state_q == ST_IDLE) && cfg_en && gnt_vld;
   // A completion coinciding with our own fire pulse belongs to nothing we started.
   assign done_ok = (state_q == ST_WAIT) && done_push && !fire_push_q;

`ifdef COMMU_SCHED_TMO_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [15:0] tmo_nxt;
   logic        err_tmo_q, err_tmo_d;

   assign tmo_nxt = tmo_cnt_q + 16'd1;
   assign tmo_hit = (state_q == ST_WAIT) && !done_ok && (tmo_nxt == 16'(TMO_CYC));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (take) begin
         tmo_cnt_d = '0;
      end else if (state_q == ST_WAIT) begin
         tmo_cnt_d = tmo_nxt;
      end
      err_tmo_d = err_tmo_q;
      if (clr_err) begin
         err_tmo_d = 1'b0;
      end
      if (tmo_hit) begin
         err_tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign err_tmo = err_tmo_q;
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign err_tmo    = 1'b0;
   assign unused_tmo = clr_err ^ (TMO_CYC == 0);
`endif

   always_comb begin
      state_d     = state_q;
      buf_sel_d   = buf_sel_q;
      fire_push_d = 1'b0;
      ack_ch0_d   = 1'b0;
      ack_ch1_d   = 1'b0;
      frm_cnt_d   = frm_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d     = ST_WAIT;
               buf_sel_d   = gnt;
               fire_push_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (done_ok || tmo_hit) begin
               if (done_ok) begin
                  ack_ch0_d = (buf_sel_q == CH0);
                  ack_ch1_d = (buf_sel_q == CH1);
                  frm_cnt_d = frm_cnt_q + 16'd1;
               end
               if (GAP_CYC == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = 16'(GAP_CYC);
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= 16'd1) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         buf_sel_q   <= CH0;
         fire_push_q <= 1'b0;
         ack_ch0_q   <= 1'b0;
         ack_ch1_q   <= 1'b0;
         busy_q      <= 1'b0;
         frm_cnt_q   <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_sel_q   <= buf_sel_d;
         fire_push_q <= fire_push_d;
         ack_ch0_q   <= ack_ch0_d;
         ack_ch1_q   <= ack_ch1_d;
         busy_q      <= busy_d;
         frm_cnt_q   <= frm_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign buf_sel   = buf_sel_q;
   assign fire_push = fire_push_q;
   assign ack_ch0   = ack_ch0_q;
   assign ack_ch1   = ack_ch1_q;
   assign busy      = busy_q;
   assign frm_cnt   = frm_cnt_q;

endmodule

// File: tb/tb_commu_sched.sv
// Directed, table-driven bench for commu_sched (GAP_CYC = 16, TMO_CYC = 50).
`timescale 1ns/1ps
module tb_commu_sched;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        cfg_en;
   logic        req_ch0;
   logic        req_ch1;
   logic        done_push;
   logic        clr_err;
   logic        ack_ch0;
   logic        ack_ch1;
   logic        buf_sel;
   logic        fire_push;
   logic        busy;
   logic        err_tmo;
   logic [15:0] frm_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk_sys = ~clk_sys;

   commu_sched #(.GAP_CYC(16), .TMO_CYC(50)) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .cfg_en    (cfg_en),
      .req_ch0   (req_ch0),
      .req_ch1   (req_ch1),
      .ack_ch0   (ack_ch0),
      .ack_ch1   (ack_ch1),
      .buf_sel   (buf_sel),
      .fire_push (fire_push),
      .done_push (done_push),
      .busy      (busy),
      .frm_cnt   (frm_cnt),
      .err_tmo   (err_tmo),
      .clr_err   (clr_err)
   );

   typedef struct {
      logic        r0;
      logic        r1;
      logic        exp_sel;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic r1);
      req_ch0 = r0;
      req_ch1 = r1;
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      checkOutput({name, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic pulseDone();
      done_push = 1'b1;
      tick();
      done_push = 1'b0;
   endtask

   // One complete frame: grant, drop req mid-WAIT, complete, check ack and count.
   task automatic runFrame(input logic r0, input logic r1, input logic exp_sel,
                           input logic [15:0] exp_cnt, input string tag);
      waitIdle(tag);
      applyStimulus(r0, r1);
      tick();
      checkOutput({tag, "_fire"}, {31'b0, fire_push}, 32'd1);
      checkOutput({tag, "_sel"}, {31'b0, buf_sel}, {31'b0, exp_sel});
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();
      checkOutput({tag, "_sel_hold"}, {31'b0, buf_sel}, {31'b0, exp_sel});
      pulseDone();
      checkOutput({tag, "_ack0"}, {31'b0, ack_ch0}, {31'b0, ~exp_sel});
      checkOutput({tag, "_ack1"}, {31'b0, ack_ch1}, {31'b0, exp_sel});
      checkOutput({tag, "_cnt"}, {16'b0, frm_cnt}, {16'b0, exp_cnt});
   endtask

   initial begin
      int n;
      int fires;
      logic ack_seen;

      vecs[0] = '{r0: 1'b1, r1: 1'b0, exp_sel: 1'b0, exp_cnt: 16'd3};
      vecs[1] = '{r0: 1'b1, r1: 1'b1, exp_sel: 1'b1, exp_cnt: 16'd4};
      vecs[2] = '{r0: 1'b1, r1: 1'b1, exp_sel: 1'b0, exp_cnt: 16'd5};
      vecs[3] = '{r0: 1'b1, r1: 1'b1, exp_sel: 1'b1, exp_cnt: 16'd6};
      vecs[4] = '{r0: 1'b0, r1: 1'b1, exp_sel: 1'b1, exp_cnt: 16'd7};
      vecs[5] = '{r0: 1'b1, r1: 1'b1, exp_sel: 1'b0, exp_cnt: 16'd8};
      vecs[6] = '{r0: 1'b1, r1: 1'b0, exp_sel: 1'b0, exp_cnt: 16'd9};
      vecs[7] = '{r0: 1'b1, r1: 1'b1, exp_sel: 1'b1, exp_cnt: 16'd10};

      rst_n = 1'b0;
      cfg_en = 1'b1;
      done_push = 1'b0;
      clr_err = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_fire", {31'b0, fire_push}, 32'd0);
      checkOutput("rst_sel", {31'b0, buf_sel}, 32'd0);
      checkOutput("rst_acks", {30'b0, ack_ch1, ack_ch0}, 32'd0);
      checkOutput("rst_cnt", {16'b0, frm_cnt}, 32'd0);
      checkOutput("rst_err", {31'b0, err_tmo}, 32'd0);
      #2 rst_n = 1'b1;
      repeat (5) tick();

      // First frame: one-cycle grant latency, then gap length before the next fire.
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("f1_fire", {31'b0, fire_push}, 32'd1);
      checkOutput("f1_sel", {31'b0, buf_sel}, 32'd0);
      checkOutput("f1_busy", {31'b0, busy}, 32'd1);
      tick();
      checkOutput("f1_fire_pulse", {31'b0, fire_push}, 32'd0);
      repeat (27) tick();
      pulseDone();
      checkOutput("f1_ack0", {31'b0, ack_ch0}, 32'd1);
      checkOutput("f1_ack1", {31'b0, ack_ch1}, 32'd0);
      checkOutput("f1_cnt", {16'b0, frm_cnt}, 32'd1);
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("f1_ack_pulse", {31'b0, ack_ch0}, 32'd0);
      n = 1;
      while (!fire_push && n < 40) begin
         tick();
         n++;
      end
      checkOutput("gap_len", n, 32'd17);
      checkOutput("f2_sel", {31'b0, buf_sel}, 32'd1);

      // done_push in the fire cycle must not complete the frame.
      done_push = 1'b1;
      tick();
      done_push = 1'b0;
      tick();
      checkOutput("early_done_ack", {31'b0, ack_ch1}, 32'd0);
      checkOutput("early_done_busy", {31'b0, busy}, 32'd1);
      checkOutput("early_done_cnt", {16'b0, frm_cnt}, 32'd1);
      pulseDone();
      checkOutput("f2_ack1", {31'b0, ack_ch1}, 32'd1);
      checkOutput("f2_cnt", {16'b0, frm_cnt}, 32'd2);
      applyStimulus(1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         runFrame(vecs[i].r0, vecs[i].r1, vecs[i].exp_sel, vecs[i].exp_cnt, $sformatf("vec%0d", i));
      end

      // cfg_en dropped mid-frame: current frame still completes, new grants blocked.
      waitIdle("cfg");
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("cfg_fire", {31'b0, fire_push}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      cfg_en = 1'b0;
      repeat (2) tick();
      pulseDone();
      checkOutput("cfg_ack0", {31'b0, ack_ch0}, 32'd1);
      checkOutput("cfg_cnt", {16'b0, frm_cnt}, 32'd11);
      waitIdle("cfg_blk");
      applyStimulus(1'b1, 1'b1);
      fires = 0;
      repeat (100) begin
         tick();
         if (fire_push) fires++;
      end
      checkOutput("cfg_blocked", fires, 32'd0);
      cfg_en = 1'b1;
      tick();
      checkOutput("cfg_resume_fire", {31'b0, fire_push}, 32'd1);
      checkOutput("cfg_resume_sel", {31'b0, buf_sel}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      tick();
      pulseDone();
      checkOutput("cfg_resume_ack1", {31'b0, ack_ch1}, 32'd1);
      checkOutput("cfg_resume_cnt", {16'b0, frm_cnt}, 32'd12);

      // Spurious completions in GAP and in IDLE.
      repeat (2) tick();
      pulseDone();
      checkOutput("gap_done_acks", {30'b0, ack_ch1, ack_ch0}, 32'd0);
      checkOutput("gap_done_cnt", {16'b0, frm_cnt}, 32'd12);
      checkOutput("gap_done_busy", {31'b0, busy}, 32'd1);
      waitIdle("idle_done");
      pulseDone();
      checkOutput("idle_done_acks", {30'b0, ack_ch1, ack_ch0}, 32'd0);
      checkOutput("idle_done_cnt", {16'b0, frm_cnt}, 32'd12);
      checkOutput("idle_done_busy", {31'b0, busy}, 32'd0);

      // Counter wrap from 0xFFFF.
      force dut.frm_cnt_q = 16'hFFFF;
      tick();
      release dut.frm_cnt_q;
      tick();
      checkOutput("preload", {16'b0, frm_cnt}, 32'h0000FFFF);
      runFrame(1'b0, 1'b1, 1'b1, 16'h0000, "wrap");

      // Withheld completion: timeout watchdog if built in, otherwise wait indefinitely.
      waitIdle("tmo");
      applyStimulus(1'b1, 1'b0);
      tick();
      checkOutput("tmo_fire", {31'b0, fire_push}, 32'd1);
      applyStimulus(1'b0, 1'b0);
`ifdef COMMU_SCHED_TMO_EN
      n = 0;
      ack_seen = 1'b0;
      while (!err_tmo && n < 80) begin
         tick();
         n++;
         if (ack_ch0 || ack_ch1) ack_seen = 1'b1;
      end
      checkOutput("tmo_cycles", n, 32'd50);
      checkOutput("tmo_no_ack", {31'b0, ack_seen}, 32'd0);
      checkOutput("tmo_gap_busy", {31'b0, busy}, 32'd1);
      checkOutput("tmo_cnt", {16'b0, frm_cnt}, 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checkOutput("tmo_clear", {31'b0, err_tmo}, 32'd0);
`else
      ack_seen = 1'b0;
      repeat (60) begin
         tick();
         if (ack_ch0 || ack_ch1) ack_seen = 1'b1;
      end
      checkOutput("notmo_err", {31'b0, err_tmo}, 32'd0);
      checkOutput("notmo_no_ack", {31'b0, ack_seen}, 32'd0);
      checkOutput("notmo_busy", {31'b0, busy}, 32'd1);
      pulseDone();
      checkOutput("notmo_ack0", {31'b0, ack_ch0}, 32'd1);
      checkOutput("notmo_cnt", {16'b0, frm_cnt}, 32'd1);
`endif
      waitIdle("pre_rst");

      // Asynchronous reset in the middle of WAIT.
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("rstw_fire", {31'b0, fire_push}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      repeat (2) tick();
      checkOutput("rstw_pre_sel", {31'b0, buf_sel}, 32'd1);
      checkOutput("rstw_pre_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstw_busy", {31'b0, busy}, 32'd0);
      checkOutput("rstw_fire0", {31'b0, fire_push}, 32'd0);
      checkOutput("rstw_sel", {31'b0, buf_sel}, 32'd0);
      checkOutput("rstw_cnt", {16'b0, frm_cnt}, 32'd0);
      #2 rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("post_rst_fire", {31'b0, fire_push}, 32'd1);
      checkOutput("post_rst_sel", {31'b0, buf_sel}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      tick();
      pulseDone();
      checkOutput("post_rst_ack1", {31'b0, ack_ch1}, 32'd1);
      checkOutput("post_rst_cnt", {16'b0, frm_cnt}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
